multi_channel_register_bank: RTL
================================

MULTI_CHANNEL_REGISTER_BANK -- requirements
Module: multi_channel_register_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per channel register, minimum 2.
REQ-002 SHALL have parameter CHANNELS, default 2: number of independent registers, minimum 1.
REQ-003 SHALL have parameter SET_VALUE, default all ones (WIDTH bits): value loaded by set.
REQ-004 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port set, input, 1: synchronous preset of all channels, active-high.
REQ-007 SHALL have port mode, input, 2*CHANNELS: per-channel op, channel i at bits [2i+1:2i].
REQ-008 SHALL have port d, input, CHANNELS*WIDTH: parallel load data, channel i at [WIDTH*i +: WIDTH].
REQ-009 SHALL have port ser_in, input, CHANNELS: per-channel serial input bit.
REQ-010 SHALL have port q, output, CHANNELS*WIDTH: registered channel values, same packing as d.
REQ-011 SHALL have port ser_out, output, CHANNELS: per-channel bit being shifted out.
REQ-012 SHALL have port snap_req, input, 1: snapshot request, sampled only when idle.
REQ-013 SHALL have port busy, output, 1: snapshot readout in progress.
REQ-014 SHALL have port rd_valid, output, 1: rd_data/rd_chan valid.
REQ-015 SHALL have port rd_ready, input, 1: consumer accepts the current word.
REQ-016 SHALL have port rd_data, output, WIDTH: snapshot word for channel rd_chan.
REQ-017 SHALL have port rd_chan, output, clog2(CHANNELS) (min 1): channel index of rd_data.

Function
REQ-018 Per channel, when set=0, the mode SHALL apply at each edge: 00 hold; 01 q<=d; 10 shift left, ser_in into LSB; 11 shift right, ser_in into MSB.
REQ-019 set=1 SHALL load SET_VALUE into every channel at the edge, overriding mode, d and ser_in.
REQ-020 Channels SHALL be independent; one channel's mode never affects another.
REQ-021 ser_out[i] SHALL be combinational: q_i[WIDTH-1] when mode_i=10, else q_i[0].
REQ-022 Snapshot FSM SHALL have two states, IDLE and SEND; busy=1 exactly in SEND.
REQ-023 IDLE with snap_req=1 at an edge SHALL copy all channel q values present before that edge (pre-update, pre-set) into a shadow, set the index to 0, and enter SEND.
REQ-024 In SEND: rd_valid=1, rd_data=shadow[index], rd_chan=index; in IDLE: rd_valid=0, rd_data=0, rd_chan=0.
REQ-025 Transfer SHALL occur on an edge with rd_valid=1 and rd_ready=1; rd_data/rd_chan SHALL hold stable while rd_ready=0.
REQ-026 On transfer, index=CHANNELS-1 SHALL return to IDLE; otherwise index increments by 1.
REQ-027 snap_req during SEND SHALL be ignored (not queued); snap_req on the edge returning to IDLE is ignored.
REQ-028 Register updates SHALL continue during SEND and SHALL NOT alter the shadow.
REQ-029 Minimum readout latency: first word valid 1 cycle after snap_req edge; N words in N cycles with rd_ready held 1.

Reset
REQ-030 rst=1 SHALL immediately, without a clock edge, force q=0 for all channels, shadow=0, index=0, FSM to IDLE, busy=0, rd_valid=0.
REQ-031 rst SHALL take priority over set, mode and snap_req; assertion mid-readout aborts it with no further words.
REQ-032 After rst deasserts, the first rising edge SHALL process set/mode/snap_req normally.

Verification (WIDTH=8, CHANNELS=2, SET_VALUE=FF)
REQ-033 rst pulse between edges -> q=0000 immediately; then set=1 one edge -> q=FFFF.
REQ-034 ch0 mode 01 d0=A5; ch1 mode 10, ser_in=1 from q1=81 -> q0=A5, q1=03, ser_out[1]=1 before edge.
REQ-035 ch0 q=01, mode 11, ser_in=0, 8 edges -> q0 00 after 1 edge, stays 00; ser_out[0]=1 on first edge.
REQ-036 q=3C_5A, snap_req=1 same edge as set=1 -> q=FFFF, readout rd_chan0=5A then rd_chan1=3C.
REQ-037 Readout with rd_ready low 3 cycles -> rd_data=5A/rd_chan=0 held; snap_req during SEND has no effect; busy falls after 2nd transfer.
REQ-038 rst asserted mid-SEND after word 0 -> busy=0, rd_valid=0 immediately; no word 1 produced.

Source files
------------

// File: rtl/multi_channel_register_bank.sv
// ---------------------------------------------------------------------------
// multi_channel_register_bank
//
// A bank of CHANNELS independent WIDTH-bit registers. Each channel holds,
// loads in parallel, or shifts left or right from its own serial input. A
// global synchronous 'set' presets every channel to SET_VALUE.
//
// A snapshot engine can capture all channel values into a shadow copy. It
// then streams the copy out one word per channel over a valid/ready
// handshake. The live registers keep updating while the stream is in
// progress.
//
// Ports
//   clk       : clock; all state changes on its rising edge
//   rst       : asynchronous, active-high reset. Clears the registers,
//               the shadow copy and the readout state.
//   set       : synchronous preset of all channels to SET_VALUE
//   mode      : 2 bits per channel (channel i at [2i+1:2i])
//               00 = hold, 01 = load d, 10 = shift left, 11 = shift right
//   d         : parallel load data, channel i at [WIDTH*i +: WIDTH]
//   ser_in    : per-channel serial input bit
//   q         : registered channel values, same packing as d
//   ser_out   : per-channel bit currently leaving the register
//   snap_req  : capture request; only honoured while idle
//   busy      : high while snapshot words are being offered
//   rd_valid  : rd_data / rd_chan hold a valid word
//   rd_ready  : consumer accepts the current word on this edge
//   rd_data   : snapshot word of channel rd_chan
//   rd_chan   : channel index of rd_data
// ---------------------------------------------------------------------------
module multi_channel_register_bank #(
  parameter int              WIDTH     = 8,
  parameter int              CHANNELS  = 2,
  parameter logic [WIDTH-1:0] SET_VALUE = '1,
  localparam int             IDX_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      set,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [CHANNELS-1:0]       ser_in,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       ser_out,
  input  logic                      snap_req,
  output logic                      busy,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [WIDTH-1:0]          rd_data,
  output logic [IDX_W-1:0]          rd_chan
);

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_SHL   = 2'b10;
  localparam logic [1:0] OP_SHR   = 2'b11;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Next value of a single channel for the given operation.
  function automatic logic [WIDTH-1:0] chan_next(
    input logic [WIDTH-1:0] cur,
    input logic [1:0]       op,
    input logic [WIDTH-1:0] load_val,
    input logic             sin
  );
    logic [WIDTH-1:0] nxt;
    case (op)
      OP_LOAD: nxt = load_val;
      OP_SHL:  nxt = {cur[WIDTH-2:0], sin};
      OP_SHR:  nxt = {sin, cur[WIDTH-1:1]};
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  logic [WIDTH-1:0] ch_q    [CHANNELS];
  logic [WIDTH-1:0] shadow  [CHANNELS];

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic             snap_load;

  // ---- Channel registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        ch_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (set) begin
          ch_q[i] <= SET_VALUE;
        end else begin
          ch_q[i] <= chan_next(ch_q[i], mode[2*i +: 2], d[WIDTH*i +: WIDTH], ser_in[i]);
        end
      end
    end
  end

  // The bit on its way out depends on the direction of the current
  // operation. A left shift drops the MSB. Every other operation presents
  // the LSB.
  always_comb begin
    ser_out = '0;
    q       = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ser_out[i]             = (mode[2*i +: 2] == OP_SHL) ? ch_q[i][WIDTH-1] : ch_q[i][0];
      q[WIDTH*i +: WIDTH]    = ch_q[i];
    end
  end

  // ---- Snapshot capture ----
  // The shadow captures ch_q as it stood before the capture edge. This
  // non-blocking copy happens on the same edge that may also apply 'set' or
  // a mode update, so the captured value is always the pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
      end
    end else if (snap_load) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= ch_q[i];
      end
    end
  end

  // ---- Readout FSM ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    snap_load = 1'b0;
    case (state)
      IDLE: begin
        if (snap_req) begin
          snap_load = 1'b1;
          idx_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        // snap_req has no effect here. A request is neither queued nor
        // honoured on the edge that returns the FSM to IDLE.
        if (rd_ready) begin
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the state alone, so rd_data and rd_chan stay
  // stable while the consumer stalls.
  always_comb begin
    busy     = (state == SEND);
    rd_valid = (state == SEND);
    rd_data  = '0;
    rd_chan  = '0;
    if (state == SEND) begin
      rd_data = shadow[idx];
      rd_chan = idx;
    end
  end

endmodule
